// File: rtl/psram_arbiter_pkg.sv
// Shared definitions for the PSRAM arbiter: sequencer state encoding,
// requester identifiers and default word-port widths.
package psram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/psram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// under contention the requester that was not granted last wins.
module rr_arb2
  import psram_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = a_req | b_req;
    if (a_req && b_req) begin
      pick = ~last_grant;
    end else if (b_req) begin
      pick = REQ_B;
    end else begin
      pick = REQ_A;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter and transaction sequencer in front of the QPI PSRAM
// driver: one access in flight, enforced CE-high gap and completion timeout.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              mem_ready,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic              read_sw,
  output logic              write_sw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              endcommand,
  output logic [1:0]        dbg_state
);

  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

  // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle
  // gnt (fields latched at that edge); its one-cycle done marks completion.
  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d, b_done_q, b_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              pick_valid;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .pick       (pick)
  );

  assign sel_we    = (pick == REQ_B) ? b_we    : a_we;
  assign sel_addr  = (pick == REQ_B) ? b_addr  : a_addr;
  assign sel_wdata = (pick == REQ_B) ? b_wdata : a_wdata;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (mem_ready && pick_valid) begin
          a_gnt_d = (pick == REQ_A);
          b_gnt_d = (pick == REQ_B);
          owner_d = pick;
          last_d  = pick;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wr_d    = sel_we;
          rd_d    = ~sel_we;
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Completion beats the timeout when both land on the same edge.
        if (endcommand || (timer_q == T_LAST)) begin
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          a_done_d = (owner_q == REQ_A);
          b_done_d = (owner_q == REQ_B);
          timer_d  = '0;
          state_d  = ST_GAP;
          if (endcommand) begin
            if (rd_q) begin
              rdata_d = mem_rdata;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (timer_q == G_LAST) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= REQ_B;
      owner_q  <= REQ_A;
      timer_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_done      = a_done_q;
  assign b_done      = b_done_q;
  assign rdata       = rdata_q;
  assign timeout_err = err_q;
  assign read_sw     = rd_q;
  assign write_sw    = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: grant vector table, directed
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_psram_arbiter;
  import psram_pkg::*;

  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 64;
  localparam int GAP = 2;

  logic          mem_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_ready = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] rdata;
  logic          timeout_err;
  logic          err_clr = 1'b0;
  logic          read_sw, write_sw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          endcommand = 1'b0;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  psram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .mem_ready(mem_ready),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done),
    .rdata(rdata), .timeout_err(timeout_err), .err_clr(err_clr),
    .read_sw(read_sw), .write_sw(write_sw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .endcommand(endcommand),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 mem_clk = ~mem_clk;
  always @(posedge mem_clk) cyc <= cyc + 1;

  // ---------------- PSRAM driver model ----------------
  // Raises endcommand dev_lat cycles after a strobe appears (never if hung).
  int            dev_lat = 4;
  bit            dev_hang = 1'b0;
  int            dev_cnt = 0;
  bit            dev_busy = 1'b0;
  logic [DW-1:0] dev_mem [logic [AW-1:0]];

  always @(posedge mem_clk) begin
    #2;
    endcommand = 1'b0;
    mem_rdata  = DW'($urandom);
    if (!rst_n || !(read_sw || write_sw)) begin
      dev_busy = 1'b0;
      dev_cnt  = 0;
    end else begin
      if (!dev_busy) begin
        dev_busy = 1'b1;
        dev_cnt  = 0;
      end
      dev_cnt++;
      if (!dev_hang && dev_cnt == dev_lat) begin
        endcommand = 1'b1;
        if (write_sw) dev_mem[mem_addr] = mem_wdata;
        else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : '0;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
    chk("exclusive", 32'({read_sw & write_sw, a_gnt & b_gnt, a_done & b_done}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; mem_ready = 1'b0;
    err_clr = 1'b0; dev_hang = 1'b0;
    repeat (2) tick();
    chk("rst_outs", 32'({a_gnt, a_done, b_gnt, b_done, read_sw, write_sw, timeout_err}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
  endtask

  // Runs one transaction for a single requester; lat==0 means the driver hangs.
  task automatic txn(input bit who, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] data, input int lat,
                     output int g_cyc, output int d_cyc);
    int n;
    dev_lat = lat; dev_hang = (lat == 0);
    g_cyc = -1; d_cyc = -1;
    if (who) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; end
    else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data; end
    n = 0;
    do begin tick(); n++; end while (!(who ? b_gnt : a_gnt) && n < 100);
    if (!(who ? b_gnt : a_gnt)) begin
      chk("txn_gnt_bound", 32'd0, 32'd1);
      a_req = 1'b0; b_req = 1'b0;
      return;
    end
    g_cyc = cyc;
    chk("txn_gnt_strobe", 32'({read_sw, write_sw}), we ? 32'd1 : 32'd2);
    chk("txn_gnt_addr", 32'(mem_addr), 32'(addr));
    if (we) chk("txn_gnt_wdata", 32'(mem_wdata), 32'(data));
    if (who) begin b_req = 1'b0; b_addr = AW'($urandom); b_wdata = DW'($urandom); end
    else begin a_req = 1'b0; a_addr = AW'($urandom); a_wdata = DW'($urandom); end
    n = 0;
    do begin
      tick(); n++;
      if (!(who ? b_done : a_done)) begin
        chk("txn_hold_strobe", 32'({read_sw, write_sw}), we ? 32'd1 : 32'd2);
        chk("txn_hold_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("txn_hold_wdata", 32'(mem_wdata), 32'(data));
      end
    end while (!(who ? b_done : a_done) && n < 200);
    if (who ? b_done : a_done) begin
      d_cyc = cyc;
      chk("txn_done_strobe", 32'({read_sw, write_sw}), 32'd0);
    end else begin
      chk("txn_done_bound", 32'd0, 32'd1);
    end
    dev_hang = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rdy, ar, aw, br, bw;
    logic          eag, ebg, erd, ewr;
    logic [AW-1:0] eaddr;
  } vec_t;
  vec_t vecs[8];

  // ---------------- random-phase model state ----------------
  bit            m_last;
  int            last_done;
  bit            infl;
  bit            inf_who, inf_we;
  logic [AW-1:0] inf_addr;
  logic [DW-1:0] inf_data;
  int            inf_done;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, d, g2, d2, n;
    int order[$];
    bit exp_done, idle, exp_g, w, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000A1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0000A1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0000B2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0000B2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0000A1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      mem_ready = vecs[i].rdy;
      a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = 24'h0000A1; a_wdata = 16'h00A1;
      b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = 24'h0000B2; b_wdata = 16'h00B2;
      tick();
      chk("vec_gnt", 32'({a_gnt, b_gnt}), 32'({vecs[i].eag, vecs[i].ebg}));
      chk("vec_strobe", 32'({read_sw, write_sw}), 32'({vecs[i].erd, vecs[i].ewr}));
      chk("vec_addr", 32'(mem_addr), 32'(vecs[i].eaddr));
      a_req = 1'b0; b_req = 1'b0;
    end

    // Init gate: no grant while mem_ready is low.
    do_reset();
    dev_lat = 3;
    a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000055; a_wdata = 16'h1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("gate_idle", 32'({a_gnt, b_gnt, read_sw, write_sw}), 32'd0);
    end
    mem_ready = 1'b1;
    tick();
    chk("gate_gnt", 32'({a_gnt, read_sw, write_sw}), 32'b101);
    a_req = 1'b0;
    repeat (3) tick();
    chk("gate_done", 32'({a_done, b_done}), 32'b10);

    // Single write with a 12-cycle driver latency.
    txn(1'b0, 1'b1, 24'h000123, 16'hBEEF, 12, g, d);
    chk("wr_latency", 32'(d - g), 32'd12);
    tick();
    chk("wr_done_pulse", 32'({a_done, read_sw, write_sw}), 32'd0);

    // Read return; request raised during GAP is granted GAP+1 after done.
    txn(1'b1, 1'b0, 24'h000123, 16'h0000, 5, g2, d2);
    chk("gap_spacing", 32'(g2 - d), 32'(GAP + 1));
    chk("rd_latency", 32'(d2 - g2), 32'd5);
    chk("rd_data", 32'(rdata), 32'hBEEF);
    txn(1'b0, 1'b1, 24'h000456, 16'h1234, 3, g, d);
    chk("rd_hold", 32'(rdata), 32'hBEEF);

    // Contention from a fresh reset: A first, then strict alternation.
    do_reset();
    mem_ready = 1'b1; dev_lat = 2;
    a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000200; a_wdata = 16'h5A5A;
    b_req = 1'b1; b_we = 1'b0; b_addr = 24'h000123; b_wdata = 16'h0000;
    n = 0;
    while (order.size() < 6 && n < 300) begin
      tick(); n++;
      if (a_gnt) order.push_back(0);
      if (b_gnt) order.push_back(1);
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("cont_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("cont_order", 32'(order[i]), 32'(i % 2));
    repeat (10) tick();
    chk("cont_rdata", 32'(rdata), 32'hBEEF);

    // Timeout: driver never completes.
    txn(1'b1, 1'b0, 24'h000123, 16'h0000, 0, g, d);
    chk("to_latency", 32'(d - g), 32'(TMO));
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_rdata", 32'(rdata), 32'hBEEF);
    tick();
    chk("to_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clear", 32'(timeout_err), 32'd0);
    txn(1'b0, 1'b0, 24'h000200, 16'h0000, 4, g, d);
    chk("to_next_latency", 32'(d - g), 32'd4);
    chk("to_next_rdata", 32'(rdata), 32'h5A5A);
    chk("to_next_err", 32'(timeout_err), 32'd0);

    // Reset in the middle of a WAIT.
    dev_hang = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 24'h000300; a_wdata = 16'h7777;
    n = 0;
    do begin tick(); n++; end while (!a_gnt && n < 50);
    chk("rmid_gnt", 32'(a_gnt), 32'd1);
    a_req = 1'b0;
    repeat (3) tick();
    chk("rmid_busy", 32'(write_sw), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_async", 32'({read_sw, write_sw, a_done, b_done}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rmid_hold", 32'({a_gnt, b_gnt, a_done, b_done, read_sw, write_sw}), 32'd0);
    end
    rst_n = 1'b1; dev_hang = 1'b0; dev_lat = 2;
    a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; b_we = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!(a_gnt || b_gnt) && n < 50);
    chk("rmid_first_a", 32'({a_gnt, b_gnt}), 32'b10);
    a_req = 1'b0; b_req = 1'b0;
    repeat (10) tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    mem_ready = 1'b1;
    m_last = 1'b1; last_done = -1000; infl = 1'b0; m_rdata = '0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      exp_done = infl && (cyc == inf_done);
      chk("rnd_done", 32'({a_done, b_done}), exp_done ? (inf_who ? 32'd1 : 32'd2) : 32'd0);
      if (exp_done) begin
        if (inf_we) ref_mem[inf_addr] = inf_data;
        else m_rdata = ref_mem.exists(inf_addr) ? ref_mem[inf_addr] : '0;
        chk("rnd_rdata", 32'(rdata), 32'(m_rdata));
        infl = 1'b0;
        last_done = cyc;
      end
      idle  = !infl && (cyc >= last_done + GAP + 1);
      exp_g = idle && mem_ready && (a_req || b_req);
      w     = (a_req && b_req) ? !m_last : b_req;
      chk("rnd_gnt", 32'({a_gnt, b_gnt}), !exp_g ? 32'd0 : (w ? 32'd1 : 32'd2));
      if (exp_g) begin
        w_we   = w ? b_we : a_we;
        w_addr = w ? b_addr : a_addr;
        w_data = w ? b_wdata : a_wdata;
        chk("rnd_strobe", 32'({read_sw, write_sw}), w_we ? 32'd1 : 32'd2);
        chk("rnd_addr", 32'(mem_addr), 32'(w_addr));
        if (w_we) chk("rnd_wdata", 32'(mem_wdata), 32'(w_data));
        dev_lat  = $urandom_range(1, 8);
        infl     = 1'b1;
        inf_who  = w; inf_we = w_we; inf_addr = w_addr; inf_data = w_data;
        inf_done = cyc + dev_lat;
        m_last   = w;
        if (w) begin b_req = 1'b0; b_addr = AW'($urandom); end
        else begin a_req = 1'b0; a_addr = AW'($urandom); end
      end
      if (!a_req && $urandom_range(0, 3) == 0) begin
        a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
        a_addr = 24'h001000 + AW'($urandom_range(0, 7)); a_wdata = DW'($urandom);
      end
      if (!b_req && $urandom_range(0, 3) == 0) begin
        b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
        b_addr = 24'h001000 + AW'($urandom_range(0, 7)); b_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 19) == 0) mem_ready = !mem_ready;
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-requester round-robin arbiter and transaction sequencer in front of the QPI PSRAM driver on the Tang Nano 1k.
- Requester A is the capture/write path; requester B is the host/readback path. Both share one PSRAM word port.
- Drives the driver's read_sw/write_sw/address/data_in.
- Waits for endcommand, returns read data, and enforces a minimum CE-high gap and a completion timeout.

Parameters:
- ADDR_W, 24, PSRAM word address width.
- DATA_W, 16, data word width.
- TIMEOUT, 64, mem_clk cycles allowed in WAIT before abort (≥2).
- GAP_CYCLES, 2, idle cycles with both strobes low between transactions (≥1).

Ports:
- mem_clk  in  1  system/PSRAM clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_ready  in  1  PSRAM init complete (qpi_on); gates new grants only.
- a_req  in  1  requester A request level.
- a_we  in  1  A: 1=write, 0=read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  one-cycle pulse: A's request accepted, inputs latched.
- a_done  out  1  one-cycle pulse: A's transaction finished.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done: same as A, for requester B.
- rdata  out  DATA_W  read data, valid in done cycle, held until next read.
- timeout_err  out  1  sticky: some transaction hit TIMEOUT.
- err_clr  in  1  clears timeout_err.
- read_sw  out  1  to driver; read strobe level.
- write_sw  out  1  to driver; write strobe level.
- mem_addr  out  ADDR_W  to driver address.
- mem_wdata  out  DATA_W  to driver data_in.
- mem_rdata  in  DATA_W  from driver data_out.
- endcommand  in  1  driver completion indication.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, last_grant=B so A wins first, timer=0, rdata=0. A reset mid-transaction drops read_sw/write_sw immediately; no done is issued.
- States: IDLE, WAIT, GAP. Encoding comes from the shared package.
- IDLE, at each edge:
  - If mem_ready=0 or no req: stay.
  - Only one req: select it.
  - Both req: select the requester ≠ last_grant.
  - At that edge: x_gnt<=1; latch addr/we/wdata into mem_addr/mem_wdata/op; exactly one of read_sw/write_sw <=1; last_grant<=x; timer<=0; ->WAIT.
- WAIT:
  - Strobe and mem_addr/mem_wdata stay stable. timer increments.
  - If endcommand=1 at an edge: strobes<=0; x_done<=1; if read, rdata<=mem_rdata; ->GAP.
  - Else if timer==TIMEOUT-1: strobes<=0; x_done<=1; rdata unchanged; timeout_err<=1; ->GAP.
  - endcommand wins if both conditions occur in the same cycle.
- GAP: both strobes low for GAP_CYCLES edges, then ->IDLE. Requests are not sampled during GAP.
- Latency: req sampled at edge N gives gnt and strobe high from N+1. The earliest done is at N+2 (endcommand seen at edge N+1). Minimum request-to-request spacing is 2+GAP_CYCLES cycles.
- Requester rules:
  - Hold req/we/addr/wdata until gnt. They may change after gnt.
  - Deasserting req after gnt does not abort the transaction.
  - req still high after done counts as a new request. Under contention, A and B alternate.
- mem_ready falling mid-transaction is ignored. It only blocks grants in IDLE.
- read_sw and write_sw are never both high.
- gnt and done are never high for both requesters in the same cycle.
- err_clr and a new timeout in the same cycle: the set wins.
- ADDR_W/DATA_W pass through unchanged; no address arithmetic.

Decomposition:
- Shared package psram_pkg holds:
  - state encoding (ST_IDLE, ST_WAIT, ST_GAP);
  - requester ids (REQ_A=0, REQ_B=1);
  - default ADDR_W/DATA_W.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick from {a_req, b_req, last_grant}.
- Timer, strobes and latching stay in psram_arbiter.

Test Plan:
- Init gate: mem_ready=0, a_req=1 for 20 cycles -> no a_gnt, strobes 0. Raise mem_ready -> a_gnt next edge, write_sw/read_sw per a_we.
- Single write: A writes addr 24'h000123, data 16'hBEEF; model asserts endcommand 12 cycles after write_sw -> mem_addr=000123, mem_wdata=BEEF stable throughout, a_done one pulse, then GAP_CYCLES low.
- Read return: B reads 24'h000123, model returns 16'hBEEF -> b_done pulse with rdata=BEEF. rdata holds through a following A write.
- Contention: a_req and b_req held high for 6 transactions -> grant order A,B,A,B,A,B; never dual gnt/done; strobes never both high.
- Timeout: model never asserts endcommand -> done at TIMEOUT=64 cycles after grant, timeout_err=1, rdata unchanged. err_clr pulse clears it. Next request proceeds normally.
- Reset mid-op: rst_n low 3 cycles into WAIT -> strobes 0 asynchronously, no done. After release, the first grant goes to A.
